// File: rtl/count_display_driver.sv
// count_display_driver
//   Time-multiplexes a 0-15 counter value and its direction onto a
//   common-anode 7-segment display. Three slots are scanned in turn:
//   units, tens (blanked when zero), and a direction glyph ('U' / 'd').
//   The counter value and direction are sampled once per frame, so a
//   frame never shows a mix of old and new values.
//
// Ports
//   clk        in   1  rising-edge clock
//   reset      in   1  asynchronous, active-high reset
//   count      in   4  value to display, 0-15
//   up_down    in   1  counter direction, 1 = up, 0 = down
//   seg        out  7  cathodes, active-low, {g,f,e,d,c,b,a}
//   an         out  4  anodes, active-low; [0] units, [1] tens, [2] dir, [3] unused
//   dp         out  1  decimal point, active-low (always off)
//   state_dbg  out  2  current scan state (0 units, 1 tens, 2 dir)
//
// There is no valid/ready handshake: count/up_down are level inputs
// sampled on the frame boundary, and the display outputs are free-running.
module count_display_driver #(
  parameter int unsigned REFRESH_DIV = 100000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] count,
  input  logic       up_down,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       dp,
  output logic [1:0] state_dbg
);

  typedef enum logic [1:0] {
    S_UNITS = 2'd0,
    S_TENS  = 2'd1,
    S_DIR   = 2'd2
  } state_t;

  localparam int unsigned PW = $clog2(REFRESH_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_UP    = 7'b1000001;
  localparam logic [6:0] SEG_DOWN  = 7'b0100001;

  logic [PW-1:0] presc;
  logic          tick;
  state_t        state, state_next;
  logic [3:0]    snap_val;
  logic          snap_dir;
  logic          capture;
  logic [3:0]    units;
  logic          tens;

  function automatic logic [6:0] seg_digit(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  assign tick    = (presc == PRESC_LAST);
  // The frame boundary is the tick that leaves the direction slot.
  assign capture = tick && (state == S_DIR);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc <= '0;
    end else if (tick) begin
      presc <= '0;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_UNITS;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      snap_val <= 4'd0;
      snap_dir <= 1'b1;
    end else if (capture) begin
      snap_val <= count;
      snap_dir <= up_down;
    end
  end

  // Binary to two BCD digits; value is at most 15 so tens is 0 or 1.
  assign tens  = (snap_val >= 4'd10);
  assign units = tens ? (snap_val - 4'd10) : snap_val;

  always_comb begin
    state_next = state;
    an         = 4'b1111;
    seg        = SEG_BLANK;
    dp         = 1'b1;
    case (state)
      S_UNITS: begin
        if (tick) state_next = S_TENS;
        an  = 4'b1110;
        seg = seg_digit(units);
      end
      S_TENS: begin
        if (tick) state_next = S_DIR;
        // Leading zero is blanked by leaving every anode off.
        if (tens) begin
          an  = 4'b1101;
          seg = seg_digit(4'd1);
        end
      end
      S_DIR: begin
        if (tick) state_next = S_UNITS;
        an  = 4'b1011;
        seg = snap_dir ? SEG_UP : SEG_DOWN;
      end
      default: begin
        state_next = S_UNITS;
      end
    endcase
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_count_display_driver.sv
module tb_count_display_driver;

  localparam int unsigned DIV = 4;

  localparam logic [1:0] ST_UNITS = 2'd0;
  localparam logic [1:0] ST_TENS  = 2'd1;
  localparam logic [1:0] ST_DIR   = 2'd2;

  localparam logic [6:0] D0 = 7'b1000000;
  localparam logic [6:0] D1 = 7'b1111001;
  localparam logic [6:0] D2 = 7'b0100100;
  localparam logic [6:0] D3 = 7'b0110000;
  localparam logic [6:0] D5 = 7'b0010010;
  localparam logic [6:0] D7 = 7'b1111000;
  localparam logic [6:0] BL = 7'b1111111;
  localparam logic [6:0] GU = 7'b1000001;
  localparam logic [6:0] GD = 7'b0100001;

  logic       clk;
  logic       reset;
  logic [3:0] count;
  logic       up_down;
  logic [6:0] seg;
  logic [3:0] an;
  logic       dp;
  logic [1:0] state_dbg;

  int errors;
  int checks;

  count_display_driver #(.REFRESH_DIV(DIV)) dut (
    .clk       (clk),
    .reset     (reset),
    .count     (count),
    .up_down   (up_down),
    .seg       (seg),
    .an        (an),
    .dp        (dp),
    .state_dbg (state_dbg)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare the display outputs against hand-computed values.
  task automatic check_out(input string tag, input logic [3:0] exp_an,
                           input logic [6:0] exp_seg);
    checks++;
    assert (an === exp_an) else begin
      errors++;
      $error("FAIL %s an: got %b expected %b", tag, an, exp_an);
    end
    checks++;
    assert (seg === exp_seg) else begin
      errors++;
      $error("FAIL %s seg: got %b expected %b", tag, seg, exp_seg);
    end
    checks++;
    assert (dp === 1'b1) else begin
      errors++;
      $error("FAIL %s dp: got %b expected 1", tag, dp);
    end
  endtask

  // Check one full slot: DIV consecutive cycles sampled at the falling
  // edge, ending on the falling edge that opens the next slot.
  task automatic check_slot(input string tag, input logic [1:0] exp_st,
                            input logic [3:0] exp_an, input logic [6:0] exp_seg);
    for (int i = 0; i < int'(DIV); i++) begin
      check_out(tag, exp_an, exp_seg);
      checks++;
      assert (state_dbg === exp_st) else begin
        errors++;
        $error("FAIL %s state cycle %0d: got %0d expected %0d", tag, i, state_dbg, exp_st);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    errors  = 0;
    checks  = 0;
    reset   = 1'b1;
    count   = 4'd7;
    up_down = 1'b1;

    // Reset values appear with no clock edge.
    #1;
    check_out("reset_no_edge", 4'b1110, D0);

    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // First frame shows the reset snapshot: 0, blank, 'U'.
    check_slot("f0_units", ST_UNITS, 4'b1110, D0);
    check_slot("f0_tens",  ST_TENS,  4'b1111, BL);
    check_slot("f0_dir",   ST_DIR,   4'b1011, GU);

    // Frame with 7 / up captured.
    check_slot("f1_units", ST_UNITS, 4'b1110, D7);
    check_slot("f1_tens",  ST_TENS,  4'b1111, BL);
    count   = 4'd12;
    up_down = 1'b0;
    check_slot("f1_dir",   ST_DIR,   4'b1011, GU);

    // Frame with 12 / down; count changes to 13 during the tens slot.
    check_slot("f2_units", ST_UNITS, 4'b1110, D2);
    count = 4'd13;
    check_slot("f2_tens",  ST_TENS,  4'b1101, D1);
    check_slot("f2_dir",   ST_DIR,   4'b1011, GD);

    // Frame with 13 / down; switch to 15 / up for the next capture.
    check_slot("f3_units", ST_UNITS, 4'b1110, D3);
    count   = 4'd15;
    up_down = 1'b1;
    check_slot("f3_tens",  ST_TENS,  4'b1101, D1);
    check_slot("f3_dir",   ST_DIR,   4'b1011, GD);

    // Frame with 15 / up; counter wraps to 0.
    check_slot("f4_units", ST_UNITS, 4'b1110, D5);
    count = 4'd0;
    check_slot("f4_tens",  ST_TENS,  4'b1101, D1);
    check_slot("f4_dir",   ST_DIR,   4'b1011, GU);

    // Frame with 0 / up after the wrap; prime 15 / down for next frame.
    check_slot("f5_units", ST_UNITS, 4'b1110, D0);
    count   = 4'd15;
    up_down = 1'b0;
    check_slot("f5_tens",  ST_TENS,  4'b1111, BL);

    // Reset mid direction slot, between clock edges.
    check_out("f5_dir_pre", 4'b1011, GU);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    check_out("midscan_reset", 4'b1110, D0);
    checks++;
    assert (state_dbg === ST_UNITS) else begin
      errors++;
      $error("FAIL midscan_reset state: got %0d expected %0d", state_dbg, ST_UNITS);
    end
    count   = 4'd9;
    @(negedge clk);
    reset = 1'b0;

    // Snapshot was cleared: 0, blank, 'U' despite count=9 / down on the inputs,
    // and the units slot lasts a full DIV cycles from a restarted prescaler.
    check_slot("r_units", ST_UNITS, 4'b1110, D0);
    check_slot("r_tens",  ST_TENS,  4'b1111, BL);
    check_slot("r_dir",   ST_DIR,   4'b1011, GU);
    check_slot("r1_units", ST_UNITS, 4'b1110, 7'b0010000);
    check_slot("r1_tens",  ST_TENS,  4'b1111, BL);
    check_slot("r1_dir",   ST_DIR,   4'b1011, GD);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
